fp_result_normalizer: RTL and testbench
=======================================

# fp_result_normalizer

Converts the raw two's-complement mantissa sum from the floating-point add/subtract datapath back into sign-magnitude form. Normalizes it iteratively, one shift per cycle, adjusting the exponent as it goes, and packs an IEEE-754 single-precision word. It sits directly downstream of the mantissa adder and is the last stage before the calculator's result register. Rounding is truncation, and subnormal results are flushed to zero.

## Interface
Parameters:
- MANT_W, 23, stored mantissa width (hidden bit excluded)
- EXP_W, 8, exponent width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- raw_sum  in  26  signed two's-complement sum of the aligned mantissas including the hidden bits; |raw_sum| < 2^25
- exp_in  in  8  biased exponent of the larger operand
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when result is valid
- result  out  32  {sign, exponent[7:0], mantissa[22:0]}; held until the next accepted start
- overflow  out  1  result saturated to ±infinity; valid with done, held with result
- underflow  out  1  nonzero result flushed to zero; valid with done, held with result

## Operation
- States: IDLE, CONVERT, NORM, DONE.
- **IDLE**
  - If start=1: latch raw_sum and exp_in (exponent widened to 9 bits internally), then go to CONVERT.
  - start is ignored in every other state.
- **CONVERT** (1 cycle)
  - Sign = raw_sum[25].
  - mag (25 bits) = sign ? −raw_sum : raw_sum.
  - If mag==0: result=0x00000000, underflow=0, go to DONE.
  - Else if exp_in==0: flush to ±0 (sign kept), underflow=1, go to DONE.
  - Else go to NORM.
- **NORM** (evaluated once per cycle, first match wins)
  1. mag[24]=1: mag>>=1, exp+=1, go to DONE. If the new exp ≥255: result={sign, 0xFF, 0}, overflow=1.
  2. mag[23]=1: already normalized, go to DONE.
  3. exp==1: flush to ±0, underflow=1, go to DONE.
  4. Otherwise: mag<<=1, exp−=1, stay in NORM.
- **DONE** (1 cycle)
  - done=1.
  - result={sign, exp[7:0], mag[22:0]} unless overridden by a zero, flush or infinity case.
  - overflow and underflow are updated here.
  - Go to IDLE.
- An exact zero always produces +0.
- No rounding: a right shift discards the LSB.

## Timing
- Reset values: busy=0, done=0, result=0, overflow=0, underflow=0; state=IDLE.
- rst has priority over everything. Asserting rst mid-operation aborts the operation, returns the block to IDLE and clears all outputs on the next edge. No done is issued for the aborted request.
- Latency, with start sampled on edge E0 and k = number of left shifts:
  - CONVERT after E0.
  - NORM after E1.
  - DONE after E(k+2).
  - done is high in the cycle after E(k+2).
- Latency bounds:
  - Minimum (already normalized, or one right shift): done in the 3rd cycle after the start cycle.
  - Maximum (mag=1, k=23): done in the 26th cycle.
  - Zero or exp_in=0 short-circuits: done in the 2nd cycle.
- busy rises the cycle after start and falls together with done's deassertion.
- A start coincident with done (block still in DONE) is ignored. The earliest accepted start is in the first IDLE cycle.

## Structure
- Package fp_norm_pkg holds:
  - the state enum
  - MANT_W, EXP_W, EXP_BIAS=127, EXP_MAX=255
  - the constants for the zero and infinity encodings
- One natural sub-module: fp_twos_to_sm, a combinational 26-bit two's-complement to sign + 25-bit magnitude converter, used in CONVERT.
- All other logic (FSM, shift register, exponent counter, output pack) lives in the top module.

## Test plan
- raw_sum=0x0800000 (2^23), exp_in=127 → result=0x3F800000, no flags, done 3 cycles after start.
- raw_sum=0x3800000 (−2^23), exp_in=128 → result=0xC0000000; sign path through fp_twos_to_sm.
- raw_sum=0x1800000, exp_in=127 → right shift, result=0x40400000. Separately, raw_sum=0x1000000, exp_in=254 → result=0x7F800000, overflow=1.
- raw_sum=0x0000001, exp_in=127 → 23 left shifts, result=0x34000000, done 26 cycles after start. Separately, raw_sum=0x0000001, exp_in=5 → result=0x00000000, underflow=1.
- raw_sum=0 → result=0x00000000, both flags 0, done in 2nd cycle. A start pulsed while busy is ignored, with exactly one done observed.
- rst asserted mid-NORM during the 23-shift case → next cycle busy=0, result=0, flags=0, no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the FP result normalizer.
// Defaults describe IEEE-754 single precision.
package fp_norm_pkg;

  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] RES_ZERO    = 32'h0000_0000;
  localparam logic [31:0] RES_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] RES_NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_NORM,
    S_DONE
  } norm_state_e;

endpackage

// File: rtl/fp_result_normalizer_if.sv
// Request/response bundle between the mantissa adder and
// the normalizer.
interface fp_result_normalizer_if
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = fp_norm_pkg::MANT_W,
  parameter int EXP_W  = fp_norm_pkg::EXP_W
);

  logic                      start;
  logic [MANT_W+2:0]         raw_sum;
  logic [EXP_W-1:0]          exp_in;
  logic                      busy;
  logic                      done;
  logic [EXP_W+MANT_W:0]     result;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output start,
    output raw_sum,
    output exp_in,
    input  busy,
    input  done,
    input  result,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  start,
    input  raw_sum,
    input  exp_in,
    output busy,
    output done,
    output result,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fp_twos_to_sm.sv
// Two's-complement to sign/magnitude converter; the input
// magnitude always fits in W-1 bits.
module fp_twos_to_sm #(
  parameter int W = 26
) (
  input  logic [W-1:0] raw,
  output logic         sign,
  output logic [W-2:0] mag
);

  logic [W-1:0] neg;

  always_comb begin
    sign = raw[W-1];
    neg  = -raw;
    mag  = sign ? neg[W-2:0] : raw[W-2:0];
  end

endmodule

// File: rtl/fp_result_normalizer.sv
// Iterative normalizer: converts the adder sum to sign/magnitude,
// shifts one bit per cycle and packs a truncated IEEE word.
module fp_result_normalizer
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = fp_norm_pkg::MANT_W,
  parameter int EXP_W  = fp_norm_pkg::EXP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_result_normalizer_if.slave  bus
);

  localparam int SUM_W = MANT_W + 3;
  localparam int MAG_W = MANT_W + 2;
  localparam int XW    = EXP_W + 1;
  localparam int RES_W = 1 + EXP_W + MANT_W;

  localparam logic [XW-1:0] EXP_SAT =
    {1'b0, {EXP_W{1'b1}}};
  localparam logic [XW-1:0] EXP_ONE = XW'(1);

  norm_state_e       state_q, state_d;
  logic [SUM_W-1:0]  raw_q, raw_d;
  logic [XW-1:0]     exp_q, exp_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              cv_sign;
  logic [MAG_W-1:0]  cv_mag;
  logic [XW-1:0]     exp_inc;
  logic [XW-1:0]     exp_dec;

  fp_twos_to_sm #(
    .W (SUM_W)
  ) u_conv (
    .raw  (raw_q),
    .sign (cv_sign),
    .mag  (cv_mag)
  );

  assign exp_inc = exp_q + EXP_ONE;
  assign exp_dec = exp_q - EXP_ONE;

  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    exp_d   = exp_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          raw_d   = bus.raw_sum;
          exp_d   = {1'b0, bus.exp_in};
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        sign_d = cv_sign;
        mag_d  = cv_mag;
        if (cv_mag == '0) begin
          // exact cancellation is always +0
          res_d   = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_q == '0) begin
          res_d   = {cv_sign, {(RES_W-1){1'b0}}};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (mag_q[MAG_W-1]) begin
          mag_d   = mag_q >> 1;
          exp_d   = exp_inc;
          unf_d   = 1'b0;
          state_d = S_DONE;
          if (exp_inc >= EXP_SAT) begin
            res_d = {sign_q, {EXP_W{1'b1}},
                     {MANT_W{1'b0}}};
            ovf_d = 1'b1;
          end else begin
            res_d = {sign_q, exp_inc[EXP_W-1:0],
                     mag_q[MANT_W:1]};
            ovf_d = 1'b0;
          end
        end else if (mag_q[MANT_W]) begin
          res_d   = {sign_q, exp_q[EXP_W-1:0],
                     mag_q[MANT_W-1:0]};
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          res_d   = {sign_q, {(RES_W-1){1'b0}}};
          ovf_d   = 1'b0;
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_dec;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      raw_q   <= '0;
      exp_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      exp_q   <= exp_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fp_result_normalizer.sv
// Scoreboard bench for fp_result_normalizer: directed vectors,
// monitor-side checking of result, flags and latency.
module tb_fp_result_normalizer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_result_normalizer_if bus ();

  fp_result_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   st_q[$];
  int   cyc       = 0;
  int   tests     = 0;
  int   fails     = 0;
  int   dones     = 0;
  int   exp_dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      int   s;
      dones++;
      if (sb.size() == 0 || st_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 want 0");
      end else begin
        e = sb.pop_front();
        s = st_q.pop_front();
        chk("result",    bus.result,          e.res);
        chk("overflow",  32'(bus.overflow),   32'(e.ovf));
        chk("underflow", 32'(bus.underflow),  32'(e.unf));
        chk("latency",   32'(cyc - s),        32'(e.lat));
      end
    end
  end

  task automatic send(input logic [25:0] raw,
                      input logic [7:0]  ex,
                      input bit          track);
    @(negedge clk);
    if (track) st_q.push_back(cyc);
    bus.start   = 1'b1;
    bus.raw_sum = raw;
    bus.exp_in  = ex;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && dones < exp_dones; i++)
      @(negedge clk);
    if (dones < exp_dones) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d dones want %0d",
               dones, exp_dones);
    end
  endtask

  task automatic run(input logic [25:0] raw,
                     input logic [7:0]  ex,
                     input logic [31:0] res,
                     input logic        ovf,
                     input logic        unf,
                     input int          lat);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.unf = unf;
    e.lat = lat;
    sb.push_back(e);
    exp_dones++;
    send(raw, ex, 1'b1);
    wait_done();
    @(negedge clk);
    chk("held_result", bus.result, res);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.raw_sum = '0;
    bus.exp_in  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_done",   32'(bus.done),      32'd0);
    chk("rst_result", bus.result,         32'd0);
    chk("rst_ovf",    32'(bus.overflow),  32'd0);
    chk("rst_unf",    32'(bus.underflow), 32'd0);
    rst = 1'b0;

    run(26'h0800000, 8'd127, 32'h3F800000, 0, 0, 3);
    run(26'h3800000, 8'd128, 32'hC0000000, 0, 0, 3);
    run(26'h1800000, 8'd127, 32'h40400000, 0, 0, 3);
    run(26'h1000000, 8'd254, 32'h7F800000, 1, 0, 3);
    run(26'h2800000, 8'd127, 32'hC0400000, 0, 0, 3);
    run(26'h0400000, 8'd127, 32'h3F000000, 0, 0, 4);
    run(26'h0000001, 8'd127, 32'h34000000, 0, 0, 26);
    run(26'h0000001, 8'd5,   32'h00000000, 0, 1, 7);
    run(26'h0000000, 8'd100, 32'h00000000, 0, 0, 2);
    run(26'h3800000, 8'd0,   32'h80000000, 0, 1, 2);
    run(26'h0000000, 8'd0,   32'h00000000, 0, 0, 2);

    // start while busy, and start coincident with done
    begin
      exp_t e;
      e.res = 32'h40000000;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      e.lat = 3;
      sb.push_back(e);
      exp_dones++;
      send(26'h0800000, 8'd128, 1'b1);
      bus.start   = 1'b1;
      bus.raw_sum = 26'h0000000;
      bus.exp_in  = 8'd0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 10 && bus.done !== 1'b1; i++)
        @(negedge clk);
      bus.start   = 1'b1;
      bus.raw_sum = 26'h0000000;
      bus.exp_in  = 8'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      chk("single_done", 32'(dones), 32'(exp_dones));
      chk("idle_after",  32'(bus.busy), 32'd0);
    end

    // abort a long normalization with reset
    send(26'h0000001, 8'd127, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",   32'(bus.busy),      32'd0);
    chk("abort_done",   32'(bus.done),      32'd0);
    chk("abort_result", bus.result,         32'd0);
    chk("abort_ovf",    32'(bus.overflow),  32'd0);
    chk("abort_unf",    32'(bus.underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(dones), 32'(exp_dones));

    run(26'h0800000, 8'd127, 32'h3F800000, 0, 0, 3);
    run(26'h1000000, 8'd255, 32'h7F800000, 1, 0, 3);

    chk("total_dones", 32'(dones), 32'(exp_dones));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
